cp0_exc_ctrl: RTL and testbench
===============================

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, the exception handler entry address.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, the number of cycles `flush` is asserted per event (legal range 1..7).
REQ-003 SHALL have ports, with clock and reset first:
- clk  input  1  clock; one clock domain, all state updates on its rising edge.
- resetn  input  1  reset; synchronous, active-low.
- ws_valid  input  1  writeback stage holds an instruction.
- ws_ready  output  1  controller accepts a commit; a commit occurs when ws_valid & ws_ready.
- ws_pc  input  32  PC of the writeback instruction.
- ws_bd  input  1  writeback instruction is in a delay slot.
- ws_eret  input  1  writeback instruction is ERET.
- ws_exc  input  7  sync exception flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL-load, [6] AdES.
- c0_status_ie  input  1  Status.IE.
- c0_status_exl  input  1  Status.EXL.
- c0_status_im  input  8  Status.IM.
- c0_cause_ip  input  8  Cause.IP.
- c0_epc  input  32  EPC value.
- wb_ex  output  1  exception strobe to CP0.
- wb_excode  output  5  ExcCode to CP0.
- wb_bd  output  1  BD to CP0.
- wb_pc  output  32  faulting PC to CP0.
- eret_flush  output  1  ERET strobe to CP0.
- flush  output  1  pipeline flush.
- redirect_valid  output  1  fetch redirect request.
- redirect_pc  output  32  redirect target.
- redirect_ready  input  1  fetch accepts the redirect.

Function
REQ-004 SHALL implement states IDLE, FLUSH and REDIRECT; ws_ready SHALL be 1 only in IDLE.
REQ-005 SHALL compute int_pend = c0_status_ie & ~c0_status_exl & |(c0_status_im & c0_cause_ip), combinationally, each cycle.
REQ-006 On a commit in IDLE SHALL select the cause by fixed priority: INT 5'h00, AdEL-fetch 5'h04, RI 5'h0a, Ov 5'h0c, Sys 5'h08, Bp 5'h09, AdEL-load 5'h04, AdES 5'h05.
REQ-007 If a cause is selected, SHALL assert wb_ex for exactly one cycle, the cycle after the commit.
- In that cycle wb_excode, wb_bd and wb_pc SHALL carry the registered excode, ws_bd and ws_pc.
- SHALL latch redirect_pc = EXC_VECTOR and enter FLUSH.
REQ-008 If no cause is selected and ws_eret=1, SHALL assert eret_flush for exactly one cycle, the cycle after the commit.
- SHALL latch redirect_pc = c0_epc sampled at the commit and enter FLUSH.
REQ-009 A commit with no cause and ws_eret=0 SHALL produce no strobes and SHALL remain in IDLE.
REQ-010 An exception cause SHALL override ERET on the same commit; eret_flush SHALL stay 0.
REQ-011 SYNC exceptions SHALL be taken with c0_status_exl=1; only INT is masked by EXL.
REQ-012 FLUSH SHALL assert flush for exactly FLUSH_CYCLES cycles, counted by a 3-bit down-counter, starting the same cycle as the wb_ex/eret_flush strobe; then SHALL enter REDIRECT.
REQ-013 REDIRECT SHALL hold redirect_valid=1 with redirect_pc stable until redirect_valid & redirect_ready, then SHALL return to IDLE the next cycle.
- redirect_ready SHALL be ignored outside REDIRECT.
REQ-014 wb_ex and eret_flush SHALL never be asserted in the same cycle; neither SHALL be asserted outside the first FLUSH cycle.
REQ-015 Minimum event-to-IDLE latency SHALL be FLUSH_CYCLES+2 cycles, with redirect_ready=1 on the first REDIRECT cycle.

Reset
REQ-016 With resetn=0 at a clock edge, SHALL enter IDLE and clear all outputs: wb_ex, eret_flush, flush, redirect_valid = 0; wb_excode = 0; wb_bd = 0; wb_pc = 0; redirect_pc = 0; flush counter = 0.
REQ-017 Reset asserted in FLUSH or REDIRECT SHALL abandon the event with no further strobe.
REQ-018 ws_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-019 Excode constants, the ws_exc bit indices and the state encoding SHALL live in the shared CPU header/package.
REQ-020 SHALL instantiate one sub-module, exc_prio_enc: combinational int_pend + ws_exc -> {hit, excode}.

Verification
REQ-021 SHALL cover: Ov commit, ws_pc=32'hBFC00100, ws_bd=0 -> next cycle wb_ex=1, wb_excode=5'h0c, wb_pc=32'hBFC00100; flush high 2 cycles; redirect_pc=32'hBFC00380.
REQ-022 SHALL cover: ERET commit with c0_epc=32'hBFC00200 -> eret_flush single pulse, redirect_pc=32'hBFC00200, wb_ex=0.
REQ-023 SHALL cover: ie=1, exl=0, im=8'h80, ip=8'h80 with ws_exc=7'h02 -> excode 5'h00 (INT wins); same stimulus with exl=1 -> excode 5'h0a.
REQ-024 SHALL cover: ws_exc=7'h60 with ws_eret=1 -> excode 5'h04, no eret_flush.
REQ-025 SHALL cover: redirect_ready held 0 for 5 cycles -> redirect_valid held, redirect_pc stable, ws_ready=0; ready=1 -> IDLE next cycle.
REQ-026 SHALL cover: resetn=0 on the second FLUSH cycle -> flush and redirect_valid 0 next cycle; ws_ready=1 after release; no wb_ex.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 exception definitions: ExcCodes, ws_exc flag positions, controller state encoding.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int EXC_W           = 7;
  localparam int EXC_BIT_ADEL_IF = 0;
  localparam int EXC_BIT_RI      = 1;
  localparam int EXC_BIT_OV      = 2;
  localparam int EXC_BIT_SYS     = 3;
  localparam int EXC_BIT_BP      = 4;
  localparam int EXC_BIT_ADEL_LD = 5;
  localparam int EXC_BIT_ADES    = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  // Interrupts are masked while EXL is set; sync exceptions are not.
  function automatic logic int_pending(input logic ie, input logic exl,
                                       input logic [7:0] im, input logic [7:0] ip);
    return ie & ~exl & (|(im & ip));
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_prio_enc.sv
// Fixed-priority exception cause encoder: interrupt first, then sync flags in pipeline order.
module exc_prio_enc
  import cp0_exc_ctrl_pkg::*;
(
  input  logic             int_pend_i,
  input  logic [EXC_W-1:0] ws_exc_i,
  output logic             hit_o,
  output logic [4:0]       excode_o
);

  always_comb begin
    hit_o    = 1'b1;
    excode_o = EXC_INT;
    if (int_pend_i)                       excode_o = EXC_INT;
    else if (ws_exc_i[EXC_BIT_ADEL_IF])   excode_o = EXC_ADEL;
    else if (ws_exc_i[EXC_BIT_RI])        excode_o = EXC_RI;
    else if (ws_exc_i[EXC_BIT_OV])        excode_o = EXC_OV;
    else if (ws_exc_i[EXC_BIT_SYS])       excode_o = EXC_SYS;
    else if (ws_exc_i[EXC_BIT_BP])        excode_o = EXC_BP;
    else if (ws_exc_i[EXC_BIT_ADEL_LD])   excode_o = EXC_ADEL;
    else if (ws_exc_i[EXC_BIT_ADES])      excode_o = EXC_ADES;
    else                                  hit_o    = 1'b0;
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Writeback-stage exception/ERET controller: strobes CP0, flushes the pipe, then redirects fetch.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ws_valid,
  output logic             ws_ready,
  input  logic [31:0]      ws_pc,
  input  logic             ws_bd,
  input  logic             ws_eret,
  input  logic [EXC_W-1:0] ws_exc,
  input  logic             c0_status_ie,
  input  logic             c0_status_exl,
  input  logic [7:0]       c0_status_im,
  input  logic [7:0]       c0_cause_ip,
  input  logic [31:0]      c0_epc,
  output logic             wb_ex,
  output logic [4:0]       wb_excode,
  output logic             wb_bd,
  output logic [31:0]      wb_pc,
  output logic             eret_flush,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic [1:0]       dbg_state
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  exc_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wb_ex_q, wb_ex_d, eret_q, eret_d, bd_q, bd_d;
  logic [4:0]  excode_q, excode_d;
  logic [31:0] pc_q, pc_d, rpc_q, rpc_d;
  logic        int_pend, hit, commit;
  logic [4:0]  excode;

  assign int_pend = int_pending(c0_status_ie, c0_status_exl, c0_status_im, c0_cause_ip);

  exc_prio_enc u_prio (
    .int_pend_i (int_pend),
    .ws_exc_i   (ws_exc),
    .hit_o      (hit),
    .excode_o   (excode)
  );

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // ws_ready is a pure function of state, redirect_valid holds with a stable pc until taken.
  assign ws_ready = (state_q == ST_IDLE);
  assign commit   = ws_valid & ws_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wb_ex_d  = 1'b0;
    eret_d   = 1'b0;
    excode_d = excode_q;
    bd_d     = bd_q;
    pc_d     = pc_q;
    rpc_d    = rpc_q;
    case (state_q)
      ST_IDLE: begin
        if (commit && hit) begin
          wb_ex_d  = 1'b1;
          excode_d = excode;
          bd_d     = ws_bd;
          pc_d     = ws_pc;
          rpc_d    = EXC_VECTOR;
          cnt_d    = FLUSH_LOAD;
          state_d  = ST_FLUSH;
        end else if (commit && ws_eret) begin
          eret_d  = 1'b1;
          rpc_d   = c0_epc;
          cnt_d   = FLUSH_LOAD;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      wb_ex_q  <= 1'b0;
      eret_q   <= 1'b0;
      excode_q <= 5'd0;
      bd_q     <= 1'b0;
      pc_q     <= 32'd0;
      rpc_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_ex_q  <= wb_ex_d;
      eret_q   <= eret_d;
      excode_q <= excode_d;
      bd_q     <= bd_d;
      pc_q     <= pc_d;
      rpc_q    <= rpc_d;
    end
  end

  assign wb_ex          = wb_ex_q;
  assign wb_excode      = excode_q;
  assign wb_bd          = bd_q;
  assign wb_pc          = pc_q;
  assign eret_flush     = eret_q;
  assign flush          = (state_q == ST_FLUSH);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = rpc_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed testbench for cp0_exc_ctrl with hand-computed expectations.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid, ws_ready, ws_bd, ws_eret;
  logic [31:0] ws_pc, c0_epc;
  logic [6:0]  ws_exc;
  logic        c0_status_ie, c0_status_exl;
  logic [7:0]  c0_status_im, c0_cause_ip;
  logic        wb_ex, wb_bd, eret_flush, flush, redirect_valid, redirect_ready;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, redirect_pc;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_exc_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_valid       (ws_valid),
    .ws_ready       (ws_ready),
    .ws_pc          (ws_pc),
    .ws_bd          (ws_bd),
    .ws_eret        (ws_eret),
    .ws_exc         (ws_exc),
    .c0_status_ie   (c0_status_ie),
    .c0_status_exl  (c0_status_exl),
    .c0_status_im   (c0_status_im),
    .c0_cause_ip    (c0_cause_ip),
    .c0_epc         (c0_epc),
    .wb_ex          (wb_ex),
    .wb_excode      (wb_excode),
    .wb_bd          (wb_bd),
    .wb_pc          (wb_pc),
    .eret_flush     (eret_flush),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .dbg_state      (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [6:0] exc, input logic eret, input logic [31:0] pc,
                        input logic bd, input logic [31:0] epc);
    ws_valid = 1'b1;
    ws_exc   = exc;
    ws_eret  = eret;
    ws_pc    = pc;
    ws_bd    = bd;
    c0_epc   = epc;
    tick();
    ws_valid = 1'b0;
    ws_exc   = 7'h00;
    ws_eret  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && ws_ready !== 1'b1; i++) tick();
    n_checks++;
    if (ws_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_idle: ws_ready=%b required 1 within 20 cycles", ws_ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; ws_valid = 1'b0; ws_pc = '0; ws_bd = 1'b0; ws_eret = 1'b0; ws_exc = '0;
    c0_status_ie = 1'b0; c0_status_exl = 1'b0; c0_status_im = '0; c0_cause_ip = '0;
    c0_epc = '0; redirect_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if ({wb_ex, eret_flush, flush, redirect_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 0000", {wb_ex, eret_flush, flush, redirect_valid});
    end
    n_checks++;
    if ({wb_excode, wb_bd, wb_pc, redirect_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: excode=%h bd=%b pc=%h rpc=%h required all 0", wb_excode, wb_bd, wb_pc, redirect_pc);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    resetn = 1'b1;
    tick();
    n_checks++;
    if (ws_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", ws_ready);
    end
  endtask

  task automatic test_ov();
    commit(7'h04, 1'b0, 32'hBFC00100, 1'b0, 32'h0);
    n_checks++;
    if ({wb_ex, wb_excode, wb_bd, eret_flush, flush, ws_ready} !== {1'b1, 5'h0c, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ov_strobe: ex=%b code=%h bd=%b eret=%b flush=%b rdy=%b required 1 0c 0 0 1 0",
               wb_ex, wb_excode, wb_bd, eret_flush, flush, ws_ready);
    end
    n_checks++;
    if (wb_pc !== 32'hBFC00100) begin
      n_fail++;
      $display("FAIL ov_pc: got %h required bfc00100", wb_pc);
    end
    tick();
    n_checks++;
    if ({wb_ex, flush, redirect_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL ov_flush2: ex/flush/rv=%b required 010", {wb_ex, flush, redirect_valid});
    end
    tick();
    n_checks++;
    if ({flush, redirect_valid, redirect_pc} !== {1'b0, 1'b1, 32'hBFC00380}) begin
      n_fail++;
      $display("FAIL ov_redirect: flush=%b rv=%b rpc=%h required 0 1 bfc00380", flush, redirect_valid, redirect_pc);
    end
    n_checks++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL ov_dbg_state: got %0d required 2", dbg_state);
    end
    tick();
    n_checks++;
    if ({ws_ready, redirect_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL ov_latency: ready/rv=%b required 10", {ws_ready, redirect_valid});
    end
  endtask

  task automatic test_eret();
    commit(7'h00, 1'b1, 32'hBFC00040, 1'b0, 32'hBFC00200);
    n_checks++;
    if ({eret_flush, wb_ex, flush} !== 3'b101) begin
      n_fail++;
      $display("FAIL eret_strobe: eret/ex/flush=%b required 101", {eret_flush, wb_ex, flush});
    end
    tick();
    n_checks++;
    if ({eret_flush, wb_ex, flush} !== 3'b001) begin
      n_fail++;
      $display("FAIL eret_single_pulse: eret/ex/flush=%b required 001", {eret_flush, wb_ex, flush});
    end
    tick();
    n_checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'hBFC00200}) begin
      n_fail++;
      $display("FAIL eret_redirect: rv=%b rpc=%h required 1 bfc00200", redirect_valid, redirect_pc);
    end
    wait_idle();
  endtask

  task automatic test_int();
    c0_status_ie = 1'b1; c0_status_exl = 1'b0; c0_status_im = 8'h80; c0_cause_ip = 8'h80;
    commit(7'h02, 1'b0, 32'hBFC00300, 1'b0, 32'h0);
    n_checks++;
    if ({wb_ex, wb_excode} !== {1'b1, 5'h00}) begin
      n_fail++;
      $display("FAIL int_wins: ex=%b code=%h required 1 00", wb_ex, wb_excode);
    end
    wait_idle();
    c0_status_exl = 1'b1;
    commit(7'h02, 1'b0, 32'hBFC00300, 1'b0, 32'h0);
    n_checks++;
    if ({wb_ex, wb_excode} !== {1'b1, 5'h0a}) begin
      n_fail++;
      $display("FAIL int_masked_exl: ex=%b code=%h required 1 0a", wb_ex, wb_excode);
    end
    wait_idle();
    c0_status_ie = 1'b0; c0_status_exl = 1'b0; c0_status_im = 8'h00; c0_cause_ip = 8'h00;
  endtask

  task automatic test_prio_over_eret();
    commit(7'h60, 1'b1, 32'hBFC00400, 1'b0, 32'hBFC00200);
    n_checks++;
    if ({wb_ex, wb_excode, eret_flush} !== {1'b1, 5'h04, 1'b0}) begin
      n_fail++;
      $display("FAIL exc_over_eret: ex=%b code=%h eret=%b required 1 04 0", wb_ex, wb_excode, eret_flush);
    end
    tick();
    n_checks++;
    if (eret_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_over_eret_later: eret=%b required 0", eret_flush);
    end
    wait_idle();
  endtask

  task automatic test_priority_table();
    logic [6:0] vec_exc [10] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h7f, 7'h7e, 7'h78};
    logic [4:0] vec_code[10] = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05, 5'h04, 5'h0a, 5'h08};
    for (int i = 0; i < 10; i++) begin
      logic        bd;
      logic [31:0] pc;
      bd = i[0];
      pc = 32'h8000_1000 + 32'(i * 4);
      commit(vec_exc[i], 1'b0, pc, bd, 32'h0);
      n_checks++;
      if ({wb_ex, wb_excode, wb_bd, wb_pc} !== {1'b1, vec_code[i], bd, pc}) begin
        n_fail++;
        $display("FAIL prio_%0d: ex=%b code=%h bd=%b pc=%h required 1 %h %b %h",
                 i, wb_ex, wb_excode, wb_bd, wb_pc, vec_code[i], bd, pc);
      end
      wait_idle();
    end
  endtask

  task automatic test_plain_commit();
    commit(7'h00, 1'b0, 32'hBFC00500, 1'b0, 32'hBFC00600);
    n_checks++;
    if ({wb_ex, eret_flush, flush, redirect_valid, ws_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL plain_commit: ex/eret/flush/rv/rdy=%b required 00001",
               {wb_ex, eret_flush, flush, redirect_valid, ws_ready});
    end
  endtask

  task automatic test_redirect_stall();
    redirect_ready = 1'b0;
    commit(7'h10, 1'b0, 32'hBFC00700, 1'b0, 32'h0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({redirect_valid, redirect_pc, ws_ready} !== {1'b1, 32'hBFC00380, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_%0d: rv=%b rpc=%h rdy=%b required 1 bfc00380 0", i, redirect_valid, redirect_pc, ws_ready);
      end
      tick();
    end
    redirect_ready = 1'b1;
    tick();
    n_checks++;
    if ({ws_ready, redirect_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL stall_release: rdy/rv=%b required 10", {ws_ready, redirect_valid});
    end
  endtask

  task automatic test_reset_mid();
    commit(7'h02, 1'b0, 32'hBFC00800, 1'b0, 32'h0);
    tick();
    n_checks++;
    if ({flush, wb_ex} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_flush2: flush/ex=%b required 10", {flush, wb_ex});
    end
    resetn = 1'b0;
    tick();
    n_checks++;
    if ({flush, redirect_valid, wb_ex, redirect_pc} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: flush=%b rv=%b ex=%b rpc=%h required 0 0 0 0", flush, redirect_valid, wb_ex, redirect_pc);
    end
    resetn = 1'b1;
    tick();
    n_checks++;
    if (ws_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready: got %b required 1", ws_ready);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({wb_ex, eret_flush, flush, redirect_valid} !== 4'b0000) begin
        n_fail++;
        $display("FAIL rstmid_quiet_%0d: got %b required 0000", i, {wb_ex, eret_flush, flush, redirect_valid});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    exp_q = '{8'd1, 8'd5, 8'd9};
    ws_valid = 1'b1; ws_exc = 7'h04; ws_eret = 1'b0; ws_pc = 32'hBFC00900; ws_bd = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (wb_ex === 1'b1) got_q.push_back(8'(t));
      n_checks++;
      if (wb_ex === 1'b1 && eret_flush !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_both_strobes_t%0d: eret=%b required 0", t, eret_flush);
      end
    end
    ws_valid = 1'b0; ws_exc = 7'h00;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b_pulse_cycle: got %0d required %0d", g, e);
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_ov();
    test_eret();
    test_int();
    test_prio_over_eret();
    test_priority_table();
    test_plain_commit();
    test_redirect_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
